// File: rtl/mbc3_pkg.sv
// Shared constants, types and helpers for the MBC3 cartridge controller.
// Address-map bases, RTC register selects and counter limits live here.
package mbc3_pkg;

    localparam logic [15:0] ROM0_BASE = 16'h0000;
    localparam logic [15:0] ROMX_BASE = 16'h4000;
    localparam logic [15:0] CRAM_BASE = 16'hA000;
    localparam logic [15:0] WRAM_BASE = 16'hC000;
    localparam logic [15:0] ECHO_END  = 16'hFDFF;

    localparam logic [7:0] RTC_S  = 8'h08;
    localparam logic [7:0] RTC_M  = 8'h09;
    localparam logic [7:0] RTC_H  = 8'h0A;
    localparam logic [7:0] RTC_DL = 8'h0B;
    localparam logic [7:0] RTC_DH = 8'h0C;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] SEC_LIM = 6'd63;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [5:0] MIN_LIM = 6'd63;
    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [4:0] HR_LIM  = 5'd31;
    localparam logic [8:0] DAY_MAX = 9'd511;

    typedef enum logic [2:0] {
        RGN_ROM0,
        RGN_ROMX,
        RGN_CRAM,
        RGN_WRAM,
        RGN_NONE
    } region_e;

    typedef struct packed {
        logic       carry;
        logic       halt;
        logic [8:0] day;
        logic [4:0] hr;
        logic [5:0] min;
        logic [5:0] sec;
    } rtc_time_t;

    function automatic region_e decodeRegion(input logic [15:0] a);
        if (a[15:14] == ROM0_BASE[15:14]) return RGN_ROM0;
        if (a[15:14] == ROMX_BASE[15:14]) return RGN_ROMX;
        if (a[15:13] == CRAM_BASE[15:13]) return RGN_CRAM;
        if (a >= WRAM_BASE && a <= ECHO_END) return RGN_WRAM;
        return RGN_NONE;
    endfunction

    // Returns {carry, next}: legal maximum wraps with carry, all-ones wraps silently.
    function automatic logic [6:0] incLimit(input logic [5:0] v,
                                            input logic [5:0] maxVal,
                                            input logic [5:0] lim);
        if (v == maxVal) return {1'b1, 6'd0};
        if (v == lim) return 7'd0;
        return {1'b0, v + 6'd1};
    endfunction

endpackage

// File: rtl/mbc3_rtc.sv
// MBC3 real-time clock: prescaler, live and latched time registers,
// software write port and latched-register read mux.
module mbc3_rtc
    import mbc3_pkg::*;
#(
    parameter int CLK_HZ = 4194304
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sel_i,
    input  logic [7:0] wdata_i,
    input  logic       we_i,
    input  logic       latch_i,
    output logic [7:0] rdata_o
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] prescaler_q, prescaler_d;
    rtc_time_t     live_q, live_d;
    rtc_time_t     latched_q, latched_d;

    logic       tick, minTick, hrTick, dayTick;
    logic [6:0] secRes, minRes;
    logic [4:0] hrInc;
    logic       wrSec, wrMin, wrHr, wrDayLo, wrDayHi;

    assign wrSec   = we_i && ({4'h0, sel_i} == RTC_S);
    assign wrMin   = we_i && ({4'h0, sel_i} == RTC_M);
    assign wrHr    = we_i && ({4'h0, sel_i} == RTC_H);
    assign wrDayLo = we_i && ({4'h0, sel_i} == RTC_DL);
    assign wrDayHi = we_i && ({4'h0, sel_i} == RTC_DH);

    // A software write to a field overrides its tick and blocks the carry out of it.
    always_comb begin
        prescaler_d = prescaler_q;
        live_d      = live_q;
        latched_d   = latch_i ? live_q : latched_q;
        tick        = 1'b0;
        secRes      = incLimit(live_q.sec, SEC_MAX, SEC_LIM);
        minRes      = incLimit(live_q.min, MIN_MAX, MIN_LIM);
        hrInc       = (live_q.hr == HR_MAX || live_q.hr == HR_LIM) ? 5'd0 : live_q.hr + 5'd1;

        if (!live_q.halt) begin
            tick        = (prescaler_q == PRE_MAX);
            prescaler_d = tick ? '0 : prescaler_q + PW'(1);
        end
        if (wrSec) prescaler_d = '0;

        minTick = tick && secRes[6] && !wrSec;
        hrTick  = minTick && minRes[6] && !wrMin;
        dayTick = hrTick && (live_q.hr == HR_MAX) && !wrHr;

        if (wrSec) live_d.sec = wdata_i[5:0];
        else if (tick) live_d.sec = secRes[5:0];

        if (wrMin) live_d.min = wdata_i[5:0];
        else if (minTick) live_d.min = minRes[5:0];

        if (wrHr) live_d.hr = wdata_i[4:0];
        else if (hrTick) live_d.hr = hrInc;

        if (dayTick) begin
            live_d.day = live_q.day + 9'd1;
            if (live_q.day == DAY_MAX) live_d.carry = 1'b1;
        end
        if (wrDayLo) begin
            live_d.day   = {live_q.day[8], wdata_i};
            live_d.carry = live_q.carry;
        end
        if (wrDayHi) begin
            live_d.day[8] = wdata_i[0];
            live_d.halt   = wdata_i[6];
            live_d.carry  = wdata_i[7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
            live_q      <= '0;
            latched_q   <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            live_q      <= live_d;
            latched_q   <= latched_d;
        end
    end

    always_comb begin
        case ({4'h0, sel_i})
            RTC_S:   rdata_o = {2'b00, latched_q.sec};
            RTC_M:   rdata_o = {2'b00, latched_q.min};
            RTC_H:   rdata_o = {3'b000, latched_q.hr};
            RTC_DL:  rdata_o = latched_q.day[7:0];
            RTC_DH:  rdata_o = {latched_q.carry, latched_q.halt, 5'b00000, latched_q.day[8]};
            default: rdata_o = 8'hFF;
        endcase
    end

endmodule

// File: rtl/mbc3_cart.sv
// MBC3 cartridge responder: banking registers, bus address decode and the
// read-data mux over ROM, cart RAM / RTC and work RAM with echo.
module mbc3_cart
    import mbc3_pkg::*;
#(
    parameter int CLK_HZ        = 4194304,
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                A,
    input  logic [7:0]                 WDATA,
    output logic [7:0]                 RDATA,
    input  logic                       RD,
    input  logic                       WR,
    input  logic                       CS,
    output logic [ROM_BANK_BITS+13:0]  ROM_ADDR,
    input  logic [7:0]                 ROM_Q,
    output logic [RAM_BANK_BITS+12:0]  RAM_ADDR,
    output logic [7:0]                 RAM_D,
    output logic                       RAM_WE,
    input  logic [7:0]                 RAM_Q,
    output logic [12:0]                WRAM_ADDR,
    output logic [7:0]                 WRAM_D,
    output logic                       WRAM_WE,
    input  logic [7:0]                 WRAM_Q
);

    region_e region;
    logic    busWr, busRd, ctrlWr, cramWr;
    logic    ramAccess, rtcAccess, latchStrobe;
    logic [7:0] rtcRdata;

    logic [ROM_BANK_BITS-1:0] romBank_q, romBank_d;
    logic [3:0]               sel_q, sel_d;
    logic                     ramEn_q, ramEn_d;
    logic [7:0]               latchPrev_q, latchPrev_d;

    // WR dominates RD, so a cycle with both strobes high is a write.
    assign region      = decodeRegion(A);
    assign busWr       = CS && WR;
    assign busRd       = CS && RD && !WR;
    assign ctrlWr      = busWr && (region == RGN_ROM0 || region == RGN_ROMX);
    assign cramWr      = busWr && (region == RGN_CRAM);
    assign ramAccess   = ramEn_q && (sel_q <= 4'd3);
    assign rtcAccess   = ramEn_q && ({4'h0, sel_q} >= RTC_S) && ({4'h0, sel_q} <= RTC_DH);
    assign latchStrobe = ctrlWr && (A[14:13] == 2'b11) && (latchPrev_q == 8'h00) && (WDATA == 8'h01);

    always_comb begin
        romBank_d   = romBank_q;
        sel_d       = sel_q;
        ramEn_d     = ramEn_q;
        latchPrev_d = latchPrev_q;
        if (ctrlWr) begin
            case (A[14:13])
                2'b00: ramEn_d = (WDATA[3:0] == 4'hA);
                2'b01: romBank_d = (WDATA[ROM_BANK_BITS-1:0] == '0) ? ROM_BANK_BITS'(1)
                                                                     : WDATA[ROM_BANK_BITS-1:0];
                2'b10: sel_d = WDATA[3:0];
                default: latchPrev_d = WDATA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            romBank_q   <= ROM_BANK_BITS'(1);
            sel_q       <= 4'h0;
            ramEn_q     <= 1'b0;
            latchPrev_q <= 8'hFF;
        end else begin
            romBank_q   <= romBank_d;
            sel_q       <= sel_d;
            ramEn_q     <= ramEn_d;
            latchPrev_q <= latchPrev_d;
        end
    end

    assign ROM_ADDR  = A[14] ? {romBank_q, A[13:0]} : {{ROM_BANK_BITS{1'b0}}, A[13:0]};
    assign RAM_ADDR  = {sel_q[RAM_BANK_BITS-1:0], A[12:0]};
    assign RAM_D     = WDATA;
    assign RAM_WE    = cramWr && ramAccess;
    assign WRAM_ADDR = A[12:0];
    assign WRAM_D    = WDATA;
    assign WRAM_WE   = busWr && (region == RGN_WRAM);

    mbc3_rtc #(
        .CLK_HZ(CLK_HZ)
    ) u_rtc (
        .clk    (clk),
        .rst    (rst),
        .sel_i  (sel_q),
        .wdata_i(WDATA),
        .we_i   (cramWr && rtcAccess),
        .latch_i(latchStrobe),
        .rdata_o(rtcRdata)
    );

    always_comb begin
        RDATA = 8'hFF;
        if (busRd) begin
            case (region)
                RGN_ROM0, RGN_ROMX: RDATA = ROM_Q;
                RGN_CRAM: begin
                    if (ramAccess) RDATA = RAM_Q;
                    else if (rtcAccess) RDATA = rtcRdata;
                end
                RGN_WRAM: RDATA = WRAM_Q;
                default: RDATA = 8'hFF;
            endcase
        end
    end

endmodule

// File: doc/mbc3_cart.md
# mbc3_cart

Responder on the work-RAM/cartridge bus driven by the LR35902 top-level (A, D_out, RD, WR, CS). Implements the full MBC3 bank controller, the cartridge-RAM window, the work-RAM window with echo, and the MBC3 real-time clock. It decodes CPU cycles, maintains the banking and RTC state, and translates them onto three external synchronous memories: ROM, cartridge RAM and WRAM. It returns read data on the CPU D_in bus.

## Interface
- CLK_HZ, 4194304, clk cycles per RTC second
- ROM_BANK_BITS, 7, ROM bank register width (128 × 16 KiB)
- RAM_BANK_BITS, 2, cart RAM bank width (4 × 8 KiB)
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- A  in  16  CPU bus address
- WDATA  in  8  CPU write data (top's D_out)
- RDATA  out  8  read data to CPU (top's D_in)
- RD, WR, CS  in  1  bus strobes, high active
- ROM_ADDR  out  ROM_BANK_BITS+14  ROM byte address
- ROM_Q  in  8  ROM read data
- RAM_ADDR  out  RAM_BANK_BITS+13  cart RAM address
- RAM_D  out  8  cart RAM write data
- RAM_WE  out  1  cart RAM write enable
- RAM_Q  in  8  cart RAM read data
- WRAM_ADDR  out  13  work RAM address
- WRAM_D  out  8  WRAM write data
- WRAM_WE  out  1  WRAM write enable
- WRAM_Q  in  8  WRAM read data

## Operation
- A cycle is valid only when CS=1. A write is CS&WR. If WR and RD are both high, the cycle is treated as a write.
- Write to 0000–1FFF: `ram_en` <= (WDATA[3:0]==4'hA).
- Write to 2000–3FFF: `rom_bank` <= WDATA[ROM_BANK_BITS-1:0]. A value of 0 is stored as 1.
- Write to 4000–5FFF: `sel` <= WDATA[3:0].
- Write to 6000–7FFF: latch the live RTC into the latched copy when the previous latch-write value was 00 and WDATA is 01. `latch_prev` <= WDATA.
- ROM reads:
  - 0000–3FFF: ROM_ADDR = {0, A[13:0]}.
  - 4000–7FFF: ROM_ADDR = {rom_bank, A[13:0]}.
  - RDATA = ROM_Q.
- A000–BFFF, cart RAM or RTC:
  - ram_en=0: RDATA = FF, writes ignored.
  - sel 0–3: RAM_ADDR = {sel[RAM_BANK_BITS-1:0], A[12:0]}, RAM_WE = write.
  - sel 08–0C: reads return the latched register; writes go to the live register.
  - Any other sel value: RDATA = FF, writes ignored.
- RTC registers:
  - 08 seconds (6b)
  - 09 minutes (6b)
  - 0A hours (5b)
  - 0B day[7:0]
  - 0C {carry, halt, 5'b0, day[8]}
  - Unused read bits return 0.
- C000–FDFF: WRAM_ADDR = A[12:0], which provides the echo region. WRAM_WE = write. RDATA = WRAM_Q.
- Any other address: RDATA = FF, and no write enable is asserted.
- RTC counting:
  - The prescaler counts 0..CLK_HZ-1 and issues a tick on wrap, unless halt=1. When halted, the prescaler is frozen.
  - Each counter (sec, min, hr) increments by 1. At its maximum legal value (59/59/23) it wraps to 0 and carries into the next counter. At its all-ones width limit it wraps to 0 with no carry.
  - day wraps 511→0 and sets the carry bit, which is sticky until software writes 0 to it.
  - A write to seconds also clears the prescaler.

## Timing
- Control registers and RTC update on the posedge following a write cycle.
- Memory outputs (ROM/RAM/WRAM addresses and enables) are combinational from A, strobes and current state.
- The external memories are synchronous-read, clocked on the falling edge. RDATA is a combinational mux of the Q inputs, valid before the next rising edge. Read latency is the same cycle.
- A bank-register write takes effect for the access in the next cycle.
- Tick and software write to the same RTC register in the same cycle: the write wins, and no carry propagates out of that register.
- The latch copies the pre-tick values if a tick coincides with the latch write.
- Reset values:
  - rom_bank=1, sel=0, ram_en=0, latch_prev=FF.
  - All live and latched RTC fields 0, halt=0, carry=0, prescaler=0.
  - RAM_WE=0, WRAM_WE=0, RDATA=FF with CS low.
- Reset asserted mid-count restores all of these values on the next edge.

## Structure
- `mbc3_pkg`:
  - Region base constants (ROM0, ROMX, CRAM, WRAM, ECHO_END).
  - RTC select localparams RTC_S=8'h08 through RTC_DH=8'h0C.
  - Counter limit constants.
- Sub-module `mbc3_rtc`:
  - Contains the prescaler, live and latched registers, the write port (sel, data, we), the latch strobe and the read mux.
  - `mbc3_cart` keeps the banking registers and address decode.

## Test plan
- Bank switching:
  - Write 2000←00, then read 4000 → ROM_ADDR=0x04000.
  - Write 2000←05, then read 4123 → ROM_ADDR=0x14123.
- RAM enable:
  - Read A000 with ram_en=0 → RDATA=FF, RAM_WE never asserts.
  - Write 0000←0A, 4000←02, then write BFFF←5A → RAM_ADDR=0x5FFF, RAM_WE=1.
- Echo: write E010←33 → WRAM_ADDR=0x0010, WRAM_WE=1. Read C010 → RDATA = WRAM_Q.
- RTC rollover (CLK_HZ=4):
  - Write sec=59, min=59, hr=23, day=511.
  - After 4 clks, latch with 6000←00 then 6000←01.
  - Reads return 0,0,0,0 and DH=0x80.
- Halt: write DH←0x40, wait 20 clks, latch → seconds unchanged. Clear halt → counting resumes after CLK_HZ clks.
- Latch and reset:
  - A lone 6000←01 after reset does not latch.
  - Asserting rst mid-count returns rom_bank=1 and all RTC fields to 0.
